// File: rtl/fault_event_logger.sv
// Fault event logger: FIFO buffering of watchdog fault events with sticky fatal map, drop counter and irq.
// Latency: an accepted event is visible on rd_valid/rd_data one cycle after acceptance (no same-cycle bypass).
// Backpressure: evt_ready is always 1; an event arriving while full with no pop is dropped and counted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   evt_valid/evt_ready   event strobe from the watchdog; ready tied high
//   evt_severity/code/ch  event payload {severity, code, channel}
//   rd_valid/rd_pop       FIFO non-empty / host pop of the head entry
//   rd_data               head entry {severity, code, ch}, first-word fall-through
//   rd_level              occupancy 0..DEPTH
//   drop_cnt/drop_clr     saturating count of events lost to a full FIFO, and its clear
//   fatal_map/fatal_clr   sticky per-channel fatal bits (severity >= 3), per-bit clear
//   irq/irq_clr           sticky interrupt, and its clear
//   rd_ts                 head entry timestamp (only with FAULT_LOG_TIMESTAMP_EN defined)
// Build option: define FAULT_LOG_TIMESTAMP_EN to capture a free-running 32-bit cycle count per entry.
module fault_event_logger #(
  parameter int NUM_CH      = 8,
  parameter int DEPTH       = 16,
  parameter int IRQ_SEV_MIN = 3,
  parameter int DROP_W      = 8,
  localparam int CHW        = $clog2(NUM_CH),
  localparam int AW         = $clog2(DEPTH),
  localparam int DW         = 12 + CHW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evt_valid,
  output logic              evt_ready,
  input  logic [3:0]        evt_severity,
  input  logic [7:0]        evt_code,
  input  logic [CHW-1:0]    evt_ch,
  output logic              rd_valid,
  input  logic              rd_pop,
  output logic [DW-1:0]     rd_data,
  output logic [AW:0]       rd_level,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              drop_clr,
  output logic [NUM_CH-1:0] fatal_map,
  input  logic [NUM_CH-1:0] fatal_clr,
  output logic              irq,
`ifdef FAULT_LOG_TIMESTAMP_EN
  input  logic              irq_clr,
  output logic [31:0]       rd_ts
`else
  input  logic              irq_clr
`endif
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic              drop_inc;
  logic              sev_fatal;
  logic              sev_irq;
  logic              ch_ok;
  logic [NUM_CH-1:0] fatal_set;

  assign evt_ready = 1'b1;
  assign full      = (level == LVL_FULL);
  assign rd_valid  = (level != '0);
  assign rd_level  = level;
  assign pop       = rd_pop && rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = evt_valid && (!full || pop);
  assign drop      = evt_valid && full && !pop;
  // Counter moves on a drop unless saturated; a clear with a drop restarts at 1.
  assign drop_inc  = drop && (drop_clr || (drop_cnt != '1));
  assign sev_fatal = evt_valid && (evt_severity >= 4'd3);
  assign sev_irq   = evt_valid && (32'(evt_severity) >= IRQ_SEV_MIN);
  // Out-of-range channel ids are still logged but never touch the map.
  assign ch_ok     = (32'(evt_ch) < NUM_CH);

  // Head is gated so the read port idles at zero while empty.
  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

  always_comb begin
    fatal_set = '0;
    if (sev_fatal && ch_ok) fatal_set[evt_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {evt_severity, evt_code, evt_ch};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      fatal_map <= '0;
      irq       <= 1'b0;
    end else begin
      if (drop_clr)      drop_cnt <= drop ? DROP_W'(1) : '0;
      else if (drop_inc) drop_cnt <= drop_cnt + DROP_W'(1);
      // New sets take priority over clears in the same cycle.
      fatal_map <= (fatal_map & ~fatal_clr) | fatal_set;
      irq       <= (irq && !irq_clr) || sev_irq || drop_inc;
    end
  end

`ifdef FAULT_LOG_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end

  // Stamp is the counter value at the accepting edge.
  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign rd_ts = rd_valid ? ts_mem[rd_ptr] : '0;
`else
  // No timestamp counter or storage in this build.
`endif

endmodule

// File: tb/tb_fault_event_logger.sv
// Directed self-checking bench for fault_event_logger with default parameters
// (NUM_CH 8, DEPTH 16, IRQ_SEV_MIN 3, DROP_W 8).
module tb_fault_event_logger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_severity;
  logic [7:0]  evt_code;
  logic [2:0]  evt_ch;
  logic        rd_valid;
  logic        rd_pop;
  logic [14:0] rd_data;
  logic [4:0]  rd_level;
  logic [7:0]  drop_cnt;
  logic        drop_clr;
  logic [7:0]  fatal_map;
  logic [7:0]  fatal_clr;
  logic        irq;
  logic        irq_clr;
`ifdef FAULT_LOG_TIMESTAMP_EN
  logic [31:0] rd_ts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fault_event_logger dut (
    .clk(clk), .rst_n(rst_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_severity(evt_severity), .evt_code(evt_code), .evt_ch(evt_ch),
    .rd_valid(rd_valid), .rd_pop(rd_pop), .rd_data(rd_data), .rd_level(rd_level),
    .drop_cnt(drop_cnt), .drop_clr(drop_clr),
    .fatal_map(fatal_map), .fatal_clr(fatal_clr),
    .irq(irq),
`ifdef FAULT_LOG_TIMESTAMP_EN
    .irq_clr(irq_clr),
    .rd_ts(rd_ts)
`else
    .irq_clr(irq_clr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] ent(input int s, input int c, input int ch);
    return {4'(s), 8'(c), 3'(ch)};
  endfunction

  task automatic set_evt(input logic v, input int s, input int c, input int ch);
    evt_valid    = v;
    evt_severity = 4'(s);
    evt_code     = 8'(c);
    evt_ch       = 3'(ch);
  endtask

  initial begin
    rst_n = 1'b0;
    set_evt(1'b0, 0, 0, 0);
    rd_pop = 1'b0; drop_clr = 1'b0; fatal_clr = '0; irq_clr = 1'b0;
    step(); step();

    // Reset state
    check("rst_evt_ready", 32'(evt_ready), 32'd1);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_rd_level",  32'(rd_level),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    check("rst_fatal_map", 32'(fatal_map), 32'd0);
    check("rst_irq",       32'(irq),       32'd0);
    rst_n = 1'b1;
    step();

    // Single recoverable event, then pop it
    set_evt(1'b1, 2, 8'h10, 5);
    step();
    set_evt(1'b0, 0, 0, 0);
    check("single_rd_valid", 32'(rd_valid),  32'd1);
    check("single_rd_data",  32'(rd_data),   32'(ent(2, 8'h10, 5)));
    check("single_irq",      32'(irq),       32'd0);
    check("single_fatal",    32'(fatal_map), 32'd0);
    check("single_level",    32'(rd_level),  32'd1);
    rd_pop = 1'b1; step(); rd_pop = 1'b0;
    check("single_pop_level", 32'(rd_level), 32'd0);
    // Pop while empty is ignored
    rd_pop = 1'b1; step(); rd_pop = 1'b0;
    check("empty_pop_level", 32'(rd_level), 32'd0);
    check("empty_pop_valid", 32'(rd_valid), 32'd0);

    // Fatal event on channel 2
    set_evt(1'b1, 3, 8'h22, 2);
    step();
    set_evt(1'b0, 0, 0, 0);
    check("fatal_map_set", 32'(fatal_map), 32'h04);
    check("fatal_irq_set", 32'(irq),       32'd1);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("irq_clr",       32'(irq),       32'd0);
    check("irq_clr_map",   32'(fatal_map), 32'h04);
    fatal_clr = 8'h04; step(); fatal_clr = '0;
    check("fatal_clr",     32'(fatal_map), 32'h00);
    // Set beats clear on the same cycle
    set_evt(1'b1, 3, 8'h23, 2);
    fatal_clr = 8'h04; irq_clr = 1'b1;
    step();
    set_evt(1'b0, 0, 0, 0);
    fatal_clr = '0; irq_clr = 1'b0;
    check("set_beats_clr_map", 32'(fatal_map), 32'h04);
    check("set_beats_clr_irq", 32'(irq),       32'd1);
    fatal_clr = 8'hFF; irq_clr = 1'b1; rd_pop = 1'b1;
    step(); step();
    fatal_clr = '0; irq_clr = 1'b0; rd_pop = 1'b0;
    check("cleanup_level", 32'(rd_level),  32'd0);
    check("cleanup_irq",   32'(irq),       32'd0);
    check("cleanup_map",   32'(fatal_map), 32'd0);

    // Push 17 low-severity events into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) begin
      set_evt(1'b1, 1, i, i % 8);
      step();
    end
    set_evt(1'b0, 0, 0, 0);
    check("full_level", 32'(rd_level), 32'd16);
    check("full_drop",  32'(drop_cnt), 32'd1);
    check("full_irq",   32'(irq),      32'd1);
    check("full_head",  32'(rd_data),  32'(ent(1, 1, 1)));

    // Full FIFO, push and pop together
    set_evt(1'b1, 1, 8'hAA, 7);
    rd_pop = 1'b1;
    step();
    set_evt(1'b0, 0, 0, 0);
    check("pushpop_level", 32'(rd_level), 32'd16);
    check("pushpop_drop",  32'(drop_cnt), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("order_%0d", i), 32'(rd_data), 32'(ent(1, i, i % 8)));
      step();
    end
    check("order_tail", 32'(rd_data), 32'(ent(1, 8'hAA, 7)));
    step();
    rd_pop = 1'b0;
    check("drained_level", 32'(rd_level), 32'd0);
    check("drained_valid", 32'(rd_valid), 32'd0);

    // Drop counter saturation
    drop_clr = 1'b1; step(); drop_clr = 1'b0;
    check("drop_clr", 32'(drop_cnt), 32'd0);
    set_evt(1'b1, 0, 0, 0);
    repeat (16 + 300) step();
    check("sat_level", 32'(rd_level), 32'd16);
    check("sat_drop",  32'(drop_cnt), 32'd255);
    drop_clr = 1'b1; step(); drop_clr = 1'b0;
    set_evt(1'b0, 0, 0, 0);
    check("clr_with_drop", 32'(drop_cnt), 32'd1);
    check("pre_rst_irq",   32'(irq),      32'd1);

    // Reset with 5 entries queued
    rd_pop = 1'b1; repeat (11) step(); rd_pop = 1'b0;
    check("pre_rst_level", 32'(rd_level), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_level", 32'(rd_level), 32'd0);
    check("mid_rst_irq",   32'(irq),      32'd0);
    check("mid_rst_drop",  32'(drop_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    set_evt(1'b1, 2, 8'h5A, 3);
    step();
    set_evt(1'b0, 0, 0, 0);
    check("post_rst_valid", 32'(rd_valid), 32'd1);
    check("post_rst_data",  32'(rd_data),  32'(ent(2, 8'h5A, 3)));
    check("post_rst_level", 32'(rd_level), 32'd1);
`ifdef FAULT_LOG_TIMESTAMP_EN
    check("post_rst_ts",    rd_ts,         32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
